sdram_cmd_sched: RTL and testbench
==================================

Name: sdram_cmd_sched

Overview:
- Command scheduler for the card's 16-bit SDRAM.
- Runs power-up init: wait, precharge-all, auto-refreshes, mode-register load.
- After init, arbitrates three requesters onto the single SDRAM command/address bus: Apple bus cycles, periodic refresh, and flash-to-SDRAM fill writes.
- Drives the command pins and the address-mux select consumed by the existing SA/SBA/DQM mux logic.

Parameters:
- TINIT, 5000: C25M cycles of NOP after reset before precharge-all (200 us).
- NINITREF, 8: auto-refreshes issued during init.
- TRFC, 2: NOP cycles after each AREF.
- TMRD, 2: NOP cycles after load-mode.
- TAPW, 3: NOP cycles after an RD/WR with auto-precharge (covers tWR+tRP).
- REFINT, 128: C25M cycles per refresh tick (5.12 us).

Ports:
- C25M  in  1  25 MHz clock; all logic on posedge.
- nRES  in  1  asynchronous active-low reset.
- apple_req  in  1  one-cycle pulse: Apple access wanted (PSStart qualified by ROM/RAM select).
- apple_we  in  1  sampled with apple_req; 1 = write.
- fill_req  in  1  level: fill word ready.
- fill_ack  out  1  pulse on the cycle the fill WR-AP is issued; upstream advances data.
- rd_valid  out  1  pulse when SD holds Apple read data (CL=2).
- sd_oe  out  1  SDRAM data bus drive enable.
- RCKE, nRCS, nRAS, nCAS, nSWE  out  1 each  SDRAM command pins.
- amux  out  3  address select: 0 mode, 1 all/precharge, 4 Apple row, 5 Apple col, 6 fill row, 7 fill col.
- init_done  out  1  high once init completes.
- ref_overrun  out  1  sticky: refresh debt overflowed.

Behaviour:
- Reset (async, nRES low): state PWRUP, all counters 0.
  - RCKE=1; nRCS/nRAS/nCAS/nSWE=1 (NOP); amux=1.
  - fill_ack, rd_valid, sd_oe, init_done, ref_overrun = 0.
  - Asserting reset mid-operation aborts immediately to these values; init reruns fully.
- Commands are registered: pins change on the posedge after the decision.
- Encodings {nRCS,nRAS,nCAS,nSWE}: NOP 1111, ACT 0011, RD 0101, WR 0100, PRE 0010, AREF 0001, LMR 0000.
  - RD/WR always carry auto-precharge (A10 via amux 5/7 encoding).
- PWRUP: NOP for TINIT cycles -> PREALL.
- PREALL: one PRE with amux=1, one NOP -> INITREF.
- INITREF: NINITREF x (AREF, TRFC NOP) -> LMR.
- LMR: LMR with amux=0, TMRD NOP -> IDLE.
  - init_done=1 on the IDLE entry cycle and stays 1 until reset.
- Apple requests during init are dropped; fill_req is ignored during init.
- Refresh debt counter (2 bits):
  - +1 every REFINT cycles, counting only after init_done.
  - -1 when a runtime AREF issues; simultaneous tick and AREF leaves it unchanged.
  - Saturates at 3; a tick at 3 sets ref_overrun.
- IDLE priority, evaluated each cycle: apple_req (or latched apple_pend) > debt≠0 > fill_req.
- APPLE sequence (relative to apple_req at cycle 0):
  - Cycle 1: ACT, amux=4.
  - Cycle 2: RD or WR, amux=5; for writes sd_oe=1 on this cycle only.
  - TAPW NOPs follow, then IDLE.
  - Reads: rd_valid pulses at cycle 4 (CL=2 after RD).
  - Total occupancy 2+TAPW cycles, always under 1 Apple PHI0 cycle.
- REF: AREF with amux=1, TRFC NOPs, then IDLE.
- FILL: ACT with amux=6; next cycle WR with amux=7, sd_oe=1, fill_ack=1; TAPW NOPs; IDLE.
- apple_req arriving in REF or FILL sets apple_pend.
  - Service starts the first IDLE cycle after completion; apple_pend clears on ACT.
  - apple_we is latched with apple_req.
  - A second apple_req while pending overwrites the pending request, with no error.
- Worst-case Apple latency is 2+TAPW+1 cycles; the Apple-side timing budget absorbs it.
- RCKE stays 1 in all states; no power-down.

Test Plan:
- Release nRES, hold 0 requests -> exactly 5000 NOPs, PRE(amux 1), 8 AREF spaced 3 cycles, LMR(amux 0); init_done high 3 cycles after LMR.
- After init, idle 128 cycles -> one AREF issued; debt returns to 0; no overrun.
- apple_req with apple_we=0 in IDLE -> ACT at +1 (amux 4), RD at +2 (amux 5), rd_valid at +4, IDLE at +5.
- fill_req held, apple_req on the cycle the fill ACT issues -> fill WR completes with one fill_ack pulse; Apple ACT issues on the first IDLE cycle, with its apple_we preserved.
- Tie fill_req=1 and apple_req every 5 cycles for 600 cycles -> debt saturates at 3, then ref_overrun=1 sticky.
- Assert nRES low during an Apple WR -> same cycle: NOP, sd_oe=0, init_done=0; on release, full init repeats.

Source files
------------

// File: rtl/sdram_cmd_sched.sv
`timescale 1ns/1ps
// SDRAM command scheduler: power-up init sequence, then arbitration of Apple
// accesses, periodic refresh and flash fill writes onto one command bus.
module sdram_cmd_sched #(
    parameter int unsigned TINIT    = 5000,
    parameter int unsigned NINITREF = 8,
    parameter int unsigned TRFC     = 2,
    parameter int unsigned TMRD     = 2,
    parameter int unsigned TAPW     = 3,
    parameter int unsigned REFINT   = 128
) (
    input  logic       C25M,
    input  logic       nRES,
    input  logic       apple_req,
    input  logic       apple_we,
    input  logic       fill_req,
    output logic       fill_ack,
    output logic       rd_valid,
    output logic       sd_oe,
    output logic       RCKE,
    output logic       nRCS,
    output logic       nRAS,
    output logic       nCAS,
    output logic       nSWE,
    output logic [2:0] amux,
    output logic       init_done,
    output logic       ref_overrun
);

    localparam int unsigned PW = $clog2(TINIT + 1);
    localparam int unsigned RW = $clog2(NINITREF + 1);
    localparam int unsigned TW = $clog2(REFINT);
    localparam int unsigned WW = 3;

    localparam logic [3:0] CMD_NOP  = 4'b1111;
    localparam logic [3:0] CMD_ACT  = 4'b0011;
    localparam logic [3:0] CMD_RD   = 4'b0101;
    localparam logic [3:0] CMD_WR   = 4'b0100;
    localparam logic [3:0] CMD_PRE  = 4'b0010;
    localparam logic [3:0] CMD_AREF = 4'b0001;
    localparam logic [3:0] CMD_LMR  = 4'b0000;

    typedef enum logic [2:0] {
        ST_PWRUP, ST_WAIT, ST_INITREF, ST_LMR, ST_IDLE, ST_APPLE, ST_FILL
    } state_t;

    state_t        state, state_n, ret, ret_n;
    logic [WW-1:0] wcnt, wcnt_n;
    logic [PW-1:0] pcnt, pcnt_n;
    logic [RW-1:0] irc, irc_n;
    logic [TW-1:0] tcnt;
    logic [1:0]    debt;
    logic [3:0]    cmd_q, cmd_n;
    logic [2:0]    amux_n;
    logic          sd_oe_n, fill_ack_n;
    logic          pend, pend_n, pend_we, pend_we_n, cur_we, cur_we_n;
    logic          rd_issue, ref_issue, tick;
    logic [1:0]    rd_sh;

    assign RCKE = 1'b1;
    assign {nRCS, nRAS, nCAS, nSWE} = cmd_q;
    assign tick = init_done && (tcnt == TW'(REFINT - 1));

    // Next-state, next-command and request latching.
    always_comb begin
        state_n    = state;
        ret_n      = ret;
        wcnt_n     = wcnt;
        pcnt_n     = pcnt;
        irc_n      = irc;
        cmd_n      = CMD_NOP;
        amux_n     = amux;
        sd_oe_n    = 1'b0;
        fill_ack_n = 1'b0;
        rd_issue   = 1'b0;
        ref_issue  = 1'b0;
        pend_n     = pend;
        pend_we_n  = pend_we;
        cur_we_n   = cur_we;

        // A request that cannot start now is held; a newer one overwrites it.
        if (apple_req && init_done && state != ST_IDLE) begin
            pend_n    = 1'b1;
            pend_we_n = apple_we;
        end

        case (state)
            ST_PWRUP: begin
                if (pcnt == PW'(TINIT)) begin
                    cmd_n   = CMD_PRE;
                    amux_n  = 3'd1;
                    wcnt_n  = '0;
                    ret_n   = ST_INITREF;
                    state_n = ST_WAIT;
                end else begin
                    pcnt_n = pcnt + PW'(1);
                end
            end
            ST_WAIT: begin
                if (wcnt == '0) state_n = ret;
                else            wcnt_n  = wcnt - WW'(1);
            end
            ST_INITREF: begin
                cmd_n   = CMD_AREF;
                amux_n  = 3'd1;
                wcnt_n  = WW'(TRFC - 1);
                irc_n   = irc + RW'(1);
                ret_n   = (irc == RW'(NINITREF - 1)) ? ST_LMR : ST_INITREF;
                state_n = ST_WAIT;
            end
            ST_LMR: begin
                cmd_n   = CMD_LMR;
                amux_n  = 3'd0;
                wcnt_n  = WW'(TMRD - 1);
                ret_n   = ST_IDLE;
                state_n = ST_WAIT;
            end
            ST_IDLE: begin
                if (apple_req || pend) begin
                    cmd_n    = CMD_ACT;
                    amux_n   = 3'd4;
                    cur_we_n = apple_req ? apple_we : pend_we;
                    pend_n   = 1'b0;
                    state_n  = ST_APPLE;
                end else if (debt != 2'd0) begin
                    cmd_n     = CMD_AREF;
                    amux_n    = 3'd1;
                    ref_issue = 1'b1;
                    wcnt_n    = WW'(TRFC - 1);
                    ret_n     = ST_IDLE;
                    state_n   = ST_WAIT;
                end else if (fill_req) begin
                    cmd_n   = CMD_ACT;
                    amux_n  = 3'd6;
                    state_n = ST_FILL;
                end
            end
            ST_APPLE: begin
                cmd_n    = cur_we ? CMD_WR : CMD_RD;
                amux_n   = 3'd5;
                sd_oe_n  = cur_we;
                rd_issue = ~cur_we;
                wcnt_n   = WW'(TAPW - 1);
                ret_n    = ST_IDLE;
                state_n  = ST_WAIT;
            end
            ST_FILL: begin
                cmd_n      = CMD_WR;
                amux_n     = 3'd7;
                sd_oe_n    = 1'b1;
                fill_ack_n = 1'b1;
                wcnt_n     = WW'(TAPW - 1);
                ret_n      = ST_IDLE;
                state_n    = ST_WAIT;
            end
            default: state_n = ST_PWRUP;
        endcase
    end

    // State, registered pins and refresh bookkeeping.
    always_ff @(posedge C25M or negedge nRES) begin
        if (!nRES) begin
            state       <= ST_PWRUP;
            ret         <= ST_PWRUP;
            wcnt        <= '0;
            pcnt        <= '0;
            irc         <= '0;
            tcnt        <= '0;
            debt        <= 2'd0;
            cmd_q       <= CMD_NOP;
            amux        <= 3'd1;
            sd_oe       <= 1'b0;
            fill_ack    <= 1'b0;
            rd_valid    <= 1'b0;
            rd_sh       <= 2'b00;
            pend        <= 1'b0;
            pend_we     <= 1'b0;
            cur_we      <= 1'b0;
            init_done   <= 1'b0;
            ref_overrun <= 1'b0;
        end else begin
            state     <= state_n;
            ret       <= ret_n;
            wcnt      <= wcnt_n;
            pcnt      <= pcnt_n;
            irc       <= irc_n;
            cmd_q     <= cmd_n;
            amux      <= amux_n;
            sd_oe     <= sd_oe_n;
            fill_ack  <= fill_ack_n;
            pend      <= pend_n;
            pend_we   <= pend_we_n;
            cur_we    <= cur_we_n;
            // CAS latency 2: data is on SD two cycles after the RD command.
            rd_sh     <= {rd_sh[0], rd_issue};
            rd_valid  <= rd_sh[1];
            init_done <= init_done | (state == ST_IDLE);
            if (init_done) tcnt <= tick ? '0 : tcnt + TW'(1);
            if (tick && !ref_issue) begin
                if (debt == 2'd3) ref_overrun <= 1'b1;
                else              debt        <= debt + 2'd1;
            end else if (!tick && ref_issue) begin
                debt <= debt - 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_sdram_cmd_sched.sv
`timescale 1ns/1ps
// Directed bench for sdram_cmd_sched: init sequence, refresh, Apple/fill
// arbitration, refresh overrun and mid-operation reset.
module tb_sdram_cmd_sched;

    localparam logic [3:0] NOP  = 4'b1111;
    localparam logic [3:0] ACT  = 4'b0011;
    localparam logic [3:0] RD   = 4'b0101;
    localparam logic [3:0] WR   = 4'b0100;
    localparam logic [3:0] PRE  = 4'b0010;
    localparam logic [3:0] AREF = 4'b0001;
    localparam logic [3:0] LMR  = 4'b0000;

    logic       C25M = 1'b0;
    logic       nRES = 1'b1;
    logic       apple_req = 1'b0;
    logic       apple_we = 1'b0;
    logic       fill_req = 1'b0;
    logic       fill_ack, rd_valid, sd_oe, RCKE, nRCS, nRAS, nCAS, nSWE;
    logic [2:0] amux;
    logic       init_done, ref_overrun;
    logic [3:0] cmdp;

    int errs = 0;
    int checks = 0;

    sdram_cmd_sched dut (
        .C25M(C25M), .nRES(nRES), .apple_req(apple_req), .apple_we(apple_we),
        .fill_req(fill_req), .fill_ack(fill_ack), .rd_valid(rd_valid), .sd_oe(sd_oe),
        .RCKE(RCKE), .nRCS(nRCS), .nRAS(nRAS), .nCAS(nCAS), .nSWE(nSWE),
        .amux(amux), .init_done(init_done), .ref_overrun(ref_overrun)
    );

    assign cmdp = {nRCS, nRAS, nCAS, nSWE};

    always #20 C25M = ~C25M;

    initial begin
        #(20000 * 40);
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic run_init();
        int n;
        logic gapbad;
        n = 0;
        gapbad = 1'b0;
        @(negedge C25M);
        while (cmdp == NOP && n < 6000) begin
            n++;
            @(negedge C25M);
        end
        chk("init_nops", n, 5000);
        chk("pre_cmd", cmdp, PRE);
        chk("pre_amux", amux, 1);
        @(negedge C25M);
        chk("pre_gap", cmdp, NOP);
        for (int i = 0; i < 8; i++) begin
            @(negedge C25M);
            chk("initref_cmd", cmdp, AREF);
            chk("initref_amux", amux, 1);
            repeat (2) begin
                @(negedge C25M);
                if (cmdp != NOP) gapbad = 1'b1;
            end
        end
        chk("initref_gap", gapbad, 0);
        chk("init_done_early", init_done, 0);
        @(negedge C25M);
        chk("lmr_cmd", cmdp, LMR);
        chk("lmr_amux", amux, 0);
        @(negedge C25M);
        chk("lmr_gap", cmdp, NOP);
        @(negedge C25M);
        chk("init_done_l2", init_done, 0);
        @(negedge C25M);
        chk("init_done_l3", init_done, 1);
    endtask

    initial begin
        int arefs, at, k;
        logic bad;

        #1 nRES = 1'b0;
        #5;
        chk("rst_cmd", cmdp, NOP);
        chk("rst_amux", amux, 1);
        chk("rst_rcke", RCKE, 1);
        chk("rst_outs", {fill_ack, rd_valid, sd_oe, init_done, ref_overrun}, 0);

        @(negedge C25M);
        @(negedge C25M);
        nRES = 1'b1;
        run_init();

        // Idle refresh: first tick lands 128 cycles in, AREF one cycle later.
        arefs = 0;
        at = 0;
        for (int i = 1; i <= 200; i++) begin
            @(negedge C25M);
            if (cmdp == AREF) begin
                arefs++;
                if (at == 0) at = i;
            end
        end
        chk("ref_lat", at, 129);
        chk("ref_cnt", arefs, 1);
        chk("ref_ovr", ref_overrun, 0);

        // Apple read from IDLE, then back-to-back write.
        apple_we = 1'b0;
        apple_req = 1'b1;
        @(negedge C25M);
        apple_req = 1'b0;
        chk("rd_act", cmdp, ACT);
        chk("rd_act_amux", amux, 4);
        @(negedge C25M);
        chk("rd_cmd", cmdp, RD);
        chk("rd_amux", amux, 5);
        chk("rd_oe", sd_oe, 0);
        @(negedge C25M);
        chk("rd_valid_c3", rd_valid, 0);
        @(negedge C25M);
        chk("rd_valid_c4", rd_valid, 1);
        @(negedge C25M);
        chk("rd_valid_c5", rd_valid, 0);
        chk("rd_c5_nop", cmdp, NOP);
        apple_we = 1'b1;
        apple_req = 1'b1;
        @(negedge C25M);
        apple_req = 1'b0;
        chk("wr_act", cmdp, ACT);
        @(negedge C25M);
        chk("wr_cmd", cmdp, WR);
        chk("wr_oe", sd_oe, 1);
        bad = 1'b0;
        repeat (3) begin
            @(negedge C25M);
            if (cmdp != NOP || sd_oe) bad = 1'b1;
        end
        chk("wr_tail", bad, 0);

        // Fill with an Apple write arriving on the fill ACT cycle.
        fill_req = 1'b1;
        k = 0;
        do begin
            @(negedge C25M);
            k++;
        end while (!(cmdp == ACT && amux == 3'd6) && k < 20);
        chk("fill_act_lat", k, 1);
        apple_we = 1'b1;
        apple_req = 1'b1;
        @(negedge C25M);
        apple_req = 1'b0;
        apple_we = 1'b0;
        fill_req = 1'b0;
        chk("fill_wr", cmdp, WR);
        chk("fill_wr_amux", amux, 7);
        chk("fill_ack", fill_ack, 1);
        chk("fill_oe", sd_oe, 1);
        bad = 1'b0;
        repeat (3) begin
            @(negedge C25M);
            if (cmdp != NOP || fill_ack) bad = 1'b1;
        end
        chk("fill_tail", bad, 0);
        @(negedge C25M);
        chk("pend_act", cmdp, ACT);
        chk("pend_act_amux", amux, 4);
        @(negedge C25M);
        chk("pend_wr", cmdp, WR);
        chk("pend_oe", sd_oe, 1);

        // Reset in the middle of the Apple write.
        #1 nRES = 1'b0;
        #1;
        chk("mid_rst_cmd", cmdp, NOP);
        chk("mid_rst_oe", sd_oe, 0);
        chk("mid_rst_done", init_done, 0);
        chk("mid_rst_amux", amux, 1);
        @(negedge C25M);
        nRES = 1'b1;
        run_init();

        // Saturate refresh debt: Apple every 5 cycles starves refresh.
        fill_req = 1'b1;
        arefs = 0;
        for (int i = 0; i < 600; i++) begin
            apple_req = (i % 5 == 0);
            apple_we = 1'(i % 2);
            @(negedge C25M);
            if (cmdp == AREF) arefs++;
            if (i == 399) chk("ovr_before", ref_overrun, 0);
        end
        chk("sat_arefs", arefs, 0);
        chk("ovr_set", ref_overrun, 1);
        apple_req = 1'b0;
        fill_req = 1'b0;
        arefs = 0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge C25M);
            if (cmdp == AREF) arefs++;
        end
        chk("drain_arefs", arefs, 3);
        chk("ovr_sticky", ref_overrun, 1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
